// File: rtl/l1_cache_nway_control_pkg.sv
// rtl/l1_cache_nway_control_pkg.sv - shared types for the N-way L1 cache controller
package l1_cache_nway_control_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        EVICT      = 2'd2,
        FETCH      = 2'd3
    } cache_state_e;

endpackage

// File: rtl/l1_cache_nway_control_if.sv
// rtl/l1_cache_nway_control_if.sv - CPU, datapath, L2 and victim-cache signals of the cache controller
interface l1_cache_nway_control_if
    import l1_cache_nway_control_pkg::*;
#(
    parameter int WAYS = 4
);
    localparam int WAY_W = $clog2(WAYS);

    logic                mem_read;
    logic                mem_write;
    logic                mem_resp;
    logic [WAYS-1:0]     hit_vec;
    logic [WAYS-1:0]     valid_vec;
    logic [WAYS-1:0]     dirty_vec;
    logic [WAYS-2:0]     plru_in;
    logic [WAYS-2:0]     plru_out;
    logic                load_plru;
    logic [WAY_W-1:0]    way_sel;
    logic [WAYS-1:0]     load_tag;
    logic [WAYS-1:0]     load_data;
    logic [WAYS-1:0]     load_valid;
    logic [WAYS-1:0]     load_dirty;
    logic                valid_set;
    logic                dirty_set;
    logic                data_src;
    logic                addr_src;
    lc3b_word            l2_address_in;
    lc3b_cacheline       l2_wdata_in;
    lc3b_word            l2_address;
    lc3b_cacheline       l2_wdata;
    logic                l2_read;
    logic                l2_write;
    logic                l2_resp;
    logic                evict_req;
    logic                evict_ack;

    modport master (
        input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_in,
               l2_address_in, l2_wdata_in, l2_resp, evict_ack,
        output mem_resp, plru_out, load_plru, way_sel, load_tag, load_data,
               load_valid, load_dirty, valid_set, dirty_set, data_src, addr_src,
               l2_address, l2_wdata, l2_read, l2_write, evict_req
    );

    modport slave (
        output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_in,
               l2_address_in, l2_wdata_in, l2_resp, evict_ack,
        input  mem_resp, plru_out, load_plru, way_sel, load_tag, load_data,
               load_valid, load_dirty, valid_set, dirty_set, data_src, addr_src,
               l2_address, l2_wdata, l2_read, l2_write, evict_req
    );

endinterface

// File: rtl/l1_cache_nway_control_plru_tree.sv
// rtl/l1_cache_nway_control_plru_tree.sv - combinational tree pseudo-LRU walk and update
module l1_cache_nway_control_plru_tree #(
    parameter int WAYS = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  plru_in,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAY_W-1:0] plru_way,
    output logic [WAYS-2:0]  plru_out
);
    // Leaves of the heap-numbered tree start at node WAYS-1, in way order.
    localparam logic [WAY_W:0] LEAF_BASE = (WAY_W+1)'(WAYS - 1);

    always_comb begin : victim_walk
        logic [WAY_W:0] node;
        logic           dir;
        node = '0;
        dir  = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir  = plru_in[node[WAY_W-1:0]];
            node = (node << 1) + (WAY_W+1)'(1) + (WAY_W+1)'(dir);
        end
        plru_way = WAY_W'(node - LEAF_BASE);
    end

    // The way index is consumed MSB first: each bit picks left (0) or right (1).
    always_comb begin : access_update
        logic [WAY_W:0]   node;
        logic [WAY_W-1:0] path;
        logic             dir;
        plru_out = plru_in;
        node     = '0;
        path     = access_way;
        dir      = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir                         = path[WAY_W-1];
            plru_out[node[WAY_W-1:0]]   = ~dir;
            node                        = (node << 1) + (WAY_W+1)'(1) + (WAY_W+1)'(dir);
            path                        = path << 1;
        end
    end

endmodule

// File: rtl/l1_cache_nway_control.sv
// rtl/l1_cache_nway_control.sv - N-way write-back L1 cache controller (hit/victim select, PLRU, miss sequencing)
module l1_cache_nway_control
    import l1_cache_nway_control_pkg::*;
#(
    parameter int WAYS = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    l1_cache_nway_control_if.master bus
);
    typedef logic [WAY_W-1:0] lc3b_way;

    cache_state_e  state;
    lc3b_way       victim_q;
    lc3b_way       hit_way;
    lc3b_way       free_way;
    lc3b_way       plru_way;
    lc3b_way       victim_way;
    logic          req_valid;
    logic          hit;
    logic          has_free;
    logic          victim_dirty;
    logic          miss;
    logic          l2_read_q;
    logic          l2_write_q;
    logic          evict_req_q;
    lc3b_word      l2_address_q;
    lc3b_cacheline l2_wdata_q;

    function automatic logic [WAYS-1:0] way_onehot(input lc3b_way w);
        return WAYS'(1) << w;
    endfunction

    l1_cache_nway_control_plru_tree #(.WAYS(WAYS)) u_plru_tree (
        .plru_in    (bus.plru_in),
        .access_way (hit_way),
        .plru_way   (plru_way),
        .plru_out   (bus.plru_out)
    );

    // Descending scan leaves the lowest matching index as the final assignment.
    always_comb begin : lowest_ways
        hit_way  = '0;
        free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.hit_vec[i])    hit_way  = lc3b_way'(i);
            if (!bus.valid_vec[i]) free_way = lc3b_way'(i);
        end
    end

    assign req_valid    = bus.mem_read ^ bus.mem_write;
    assign hit          = |bus.hit_vec;
    assign has_free     = ~&bus.valid_vec;
    assign victim_way   = has_free ? free_way : plru_way;
    assign victim_dirty = bus.dirty_vec[victim_way];
    assign miss         = req_valid & ~hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            victim_q     <= '0;
            l2_address_q <= '0;
            l2_wdata_q   <= '0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            evict_req_q  <= 1'b0;
        end else begin
            l2_address_q <= bus.l2_address_in;
            l2_wdata_q   <= bus.l2_wdata_in;
            case (state)
                IDLE: begin
                    if (miss) begin
                        victim_q <= victim_way;
                        if (has_free) begin
                            state     <= FETCH;
                            l2_read_q <= 1'b1;
                        end else if (victim_dirty) begin
                            state      <= WRITE_BACK;
                            l2_write_q <= 1'b1;
                        end else begin
                            state       <= EVICT;
                            evict_req_q <= 1'b1;
                        end
                    end
                end
                WRITE_BACK: begin
                    if (bus.l2_resp) begin
                        state      <= FETCH;
                        l2_write_q <= 1'b0;
                        l2_read_q  <= 1'b1;
                    end
                end
                EVICT: begin
                    if (bus.evict_ack) begin
                        state       <= FETCH;
                        evict_req_q <= 1'b0;
                        l2_read_q   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.l2_resp) begin
                        state     <= IDLE;
                        l2_read_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address/data mux selects lead the registered L2 copies by one cycle.
    always_comb begin
        bus.mem_resp   = 1'b0;
        bus.load_plru  = 1'b0;
        bus.way_sel    = '0;
        bus.load_tag   = '0;
        bus.load_data  = '0;
        bus.load_valid = '0;
        bus.load_dirty = '0;
        bus.valid_set  = 1'b0;
        bus.dirty_set  = 1'b0;
        bus.data_src   = 1'b0;
        bus.addr_src   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && hit) begin
                    bus.mem_resp  = 1'b1;
                    bus.load_plru = 1'b1;
                    bus.way_sel   = hit_way;
                    if (bus.mem_write) begin
                        bus.load_tag   = way_onehot(hit_way);
                        bus.load_data  = way_onehot(hit_way);
                        bus.load_dirty = way_onehot(hit_way);
                        bus.dirty_set  = 1'b1;
                    end
                end else if (miss) begin
                    bus.way_sel  = victim_way;
                    bus.addr_src = ~has_free;
                end
            end
            WRITE_BACK: begin
                bus.way_sel  = victim_q;
                bus.addr_src = ~bus.l2_resp;
            end
            EVICT: begin
                bus.way_sel = victim_q;
            end
            FETCH: begin
                bus.way_sel = victim_q;
                if (bus.l2_resp) begin
                    bus.load_tag   = way_onehot(victim_q);
                    bus.load_data  = way_onehot(victim_q);
                    bus.load_valid = way_onehot(victim_q);
                    bus.load_dirty = way_onehot(victim_q);
                    bus.valid_set  = 1'b1;
                    bus.data_src   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.l2_address = l2_address_q;
    assign bus.l2_wdata   = l2_wdata_q;
    assign bus.l2_read    = l2_read_q;
    assign bus.l2_write   = l2_write_q;
    assign bus.evict_req  = evict_req_q;

endmodule

// File: doc/l1_cache_nway_control.md
# l1_cache_nway_control

Control unit for a WAYS-way set-associative, write-back L1 cache, replacing the fixed 2-way controller. It sits between the CPU memory port and L2, alongside the tag/data datapath. It selects hit and victim ways, maintains tree pseudo-LRU state, and sequences write-back, victim-cache eviction and line fill against L2. New relative to the 2-way unit:
- way count is parametrised;
- an invalid way is preferred over the PLRU victim;
- the victim-cache eviction uses a full req/ack handshake;
- the victim way is latched at miss time.

## Interface
Parameters:
- WAYS, 4, number of ways; power of two, 2..8
- WAY_W, $clog2(WAYS), way index width (derived; do not override)

Ports. The clock is `clk`; reset is asynchronous and active-low (`rst_n`).
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_read, mem_write  in  1  CPU request; held stable until mem_resp
- mem_resp  out  1  CPU request complete
- hit_vec, valid_vec, dirty_vec  in  WAYS  per-way status for the addressed set
- plru_in  in  WAYS-1  PLRU tree bits for the addressed set
- plru_out  out  WAYS-1  updated tree bits
- load_plru  out  1  write plru_out to the set
- way_sel  out  WAY_W  datapath way mux select (L2 wdata, victim tag address)
- load_tag, load_data, load_valid, load_dirty  out  WAYS  per-way load strobes
- valid_set, dirty_set  out  1  value written with the load strobes
- data_src  out  1  0 = CPU write data, 1 = L2 line
- addr_src  out  1  0 = CPU address, 1 = victim tag address of way_sel
- l2_address_in  in  16  lc3b_word from the address mux
- l2_wdata_in  in  128  lc3b_cacheline from the way mux
- l2_address  out  16  registered copy of l2_address_in
- l2_wdata  out  128  registered copy of l2_wdata_in
- l2_read, l2_write  out  1  L2 request, held until l2_resp
- l2_resp  in  1  L2 completion
- evict_req  out  1  victim-cache write request, held until evict_ack
- evict_ack  in  1  victim cache accepted the line

## Operation
A request is valid only when mem_read XOR mem_write. When both or neither are asserted: no response, no state change, all strobes 0.

**Hit way.** The hit way is the lowest set index of hit_vec.

**PLRU tree.**
- Node 0 is the root; node i has children 2i+1 and 2i+2.
- A bit of 0 points the victim toward the left child, 1 toward the right. Traverse from the root to a leaf to get the PLRU way.
- On access of way w, set every node on w's path to point away from w.
- WAYS=2: one bit, and 0 means the victim is way 0.

**Victim way.** The lowest-index way with valid_vec=0 if one exists, otherwise the PLRU way.

**States:** IDLE, WRITE_BACK, EVICT, FETCH.

IDLE:
- Read hit: mem_resp=1, load_plru=1, plru_out updated for the hit way, way_sel = hit way.
- Write hit: the same, plus load_data[w], load_dirty[w] and load_tag[w] asserted, with dirty_set=1 and data_src=0.
- Miss: latch the victim into victim_q, drive way_sel = victim, then branch:
  - victim valid and dirty: go to WRITE_BACK, with addr_src=1 this cycle;
  - victim valid and clean: go to EVICT, with addr_src=1 this cycle;
  - victim invalid: go to FETCH, with addr_src=0.

WRITE_BACK:
- Drives l2_write=1, way_sel=victim_q, addr_src=1.
- On l2_resp: addr_src=0 and go to FETCH.

EVICT:
- Drives evict_req=1, way_sel=victim_q, addr_src=0.
- On evict_ack: go to FETCH.

FETCH:
- Drives l2_read=1 and addr_src=0.
- On l2_resp, for way victim_q, in one cycle: load_tag, load_data (data_src=1), load_valid (valid_set=1) and load_dirty (dirty_set=0). Then go to IDLE, where the request is re-evaluated as a hit.

## Timing
- Hit: mem_resp is combinational in the same cycle; zero wait states.
- l2_address and l2_wdata are registered every cycle. The mux selects are therefore driven one cycle ahead, in the state transition cycle, as specified above.
- Miss latency:
  - clean or invalid victim: 1 + L2 fill + 1 cycles;
  - dirty victim: adds L2 write-back cycles;
  - valid clean victim: adds the EVICT handshake cycles (at least 1).
- victim_q changes only in an IDLE miss cycle. PLRU changes during the miss do not affect the in-flight victim.
- Reset values: state IDLE, victim_q 0, l2_address 0, l2_wdata 0. All outputs 0 except plru_out, which is combinational from plru_in.
- Reset asserted mid-operation: immediate return to IDLE; l2_read, l2_write and evict_req drop asynchronously. L2 and the victim cache must tolerate the abort. Partially loaded lines are never marked valid.
- l2_resp outside WRITE_BACK/FETCH and evict_ack outside EVICT are ignored.

## Structure
- lc3b_types gains lc3b_way (logic [WAY_W-1:0]) and the state enum.
- Sub-module plru_tree: purely combinational. Maps plru_in to the PLRU way, and (plru_in, way) to plru_out. It is instanced once in this block.

## Test plan
All scenarios use WAYS=4; plru bits are [2:0] = {node2, node1, root}.
- Read hit way 2, plru_in=000 -> mem_resp=1 and load_plru=1 in the same cycle, plru_out=100.
- Write hit way 1, plru_in=111 -> load_data[1], load_dirty[1] and dirty_set=1 asserted; plru_out=101; mem_resp=1.
- Miss, valid_vec=1111, dirty_vec=0001, plru_in=000 -> victim 0. WRITE_BACK with l2_write for 3 cycles until l2_resp. FETCH until l2_resp, then load_tag[0] and load_valid[0] asserted. Return to IDLE, then hit.
- Miss, valid_vec=1011 -> victim 2 regardless of plru_in; goes directly to FETCH; no l2_write, no evict_req.
- Miss, clean valid victim 3 -> evict_req held 3 cycles until evict_ack, then l2_read next cycle.
- rst_n low during the second FETCH cycle -> l2_read=0 immediately; no load strobes; IDLE after rst_n release. mem_read=mem_write=1 -> mem_resp stays 0 indefinitely.
